// File: rtl/mdu_exec_pkg.sv
// Shared pipeline constants for the multiply/divide unit: HI/LO op codes,
// default latencies and the sequencer state encoding.
package mdu_exec_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_exec.sv
// E-stage multiply/divide unit: results are computed on the accepting edge,
// parked in temp registers, and released to HI/LO after a fixed busy window.
module mdu_exec
    import mdu_exec_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC,
    parameter int DIV_CYC  = MD_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output mdu_state_e  state
);

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYC);

    logic [3:0]         cnt;
    logic [31:0]        hi_t;
    logic [31:0]        lo_t;
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quo;
    logic [31:0]        rem;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divide by zero parks the current HI/LO, so completion leaves them as they were.
    always_comb begin
        quo = LO;
        rem = HI;
        if (B != 32'd0) begin
            if (op == MD_DIVU) begin
                quo = A / B;
                rem = A % B;
            end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = 32'd0;
            end else begin
                quo = $unsigned($signed(A) / $signed(B));
                rem = $unsigned($signed(A) % $signed(B));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            hi_t  <= 32'd0;
            lo_t  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                {hi_t, lo_t} <= (op == MD_MULT) ? prod_s : prod_u;
                                cnt   <= MULT_LAT;
                                busy  <= 1'b1;
                                state <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                hi_t  <= rem;
                                lo_t  <= quo;
                                cnt   <= DIV_LAT;
                                busy  <= 1'b1;
                                state <= ST_DIV;
                            end
                            MD_MTHI: HI <= A;
                            MD_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                // Any start seen here is dropped; the hazard unit stalls on busy.
                ST_MUL, ST_DIV: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        HI    <= hi_t;
                        LO    <= lo_t;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_exec.sv
// Self-checking bench for mdu_exec: scenario tasks with a scoreboard queue of
// expected {HI,LO} values produced by an independent arithmetic model.
module tb_mdu_exec;
    import mdu_exec_pkg::*;

    // Handshake: start/op/A/B are driven after a negedge and sampled by the DUT
    // on the following posedge; outputs are checked on negedges.
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = MD_NONE;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    mdu_state_e  state;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_exec #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference arithmetic using 64-bit longint math; updates the model HI/LO.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] r;
        r  = {m_hi, m_lo};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MD_MULT: begin
                p = sa * sb;
                r = p;
            end
            MD_MULTU: r = {32'd0, a} * {32'd0, b};
            MD_DIVU: if (b != 0) r = {a % b, a / b};
            MD_DIV: if (b != 0) begin
                p = sa / sb;
                r = {32'(sa - p * sb), 32'(p)};
            end
            default: ;
        endcase
        m_hi = r[63:32];
        m_lo = r[31:0];
        return r;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic inject, input logic [2:0] inj_op,
                         input string name);
        logic [63:0] exp_v;
        int cyc;
        start = 1'b1; op = o; A = a; B = b;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0; op = MD_NONE; A = $urandom; B = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_rise: got %b want 1", name, busy);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (inject && cyc == 2) begin
                start = 1'b1; op = inj_op; A = $urandom; B = $urandom;
            end
            @(negedge clk);
            start = 1'b0; op = MD_NONE;
            cyc++;
        end
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, cyc, exp_cyc);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({HI, LO} !== exp_v) begin
            errors++;
            $display("FAIL %s_result: got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, exp_v[63:32], exp_v[31:0]);
        end
    endtask

    task automatic do_move(input logic [2:0] o, input logic [31:0] a, input string name);
        start = 1'b1; op = o; A = a; B = $urandom;
        if (o == MD_MTHI) m_hi = a;
        if (o == MD_MTLO) m_lo = a;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL %s: got busy=%b HI=%h LO=%h want busy=0 HI=%h LO=%h", name, busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got busy=%b HI=%h LO=%h state=%0d want 0/0/0/IDLE", busy, HI, LO, state);
        end
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        // First op right after release must be taken on the very next posedge.
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, MD_NONE, "mult_neg2x3");
    endtask

    task automatic test_div();
        do_op(MD_DIVU, 32'd100, 32'd7, 10, 1'b0, MD_NONE, "divu_100_7");
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, MD_NONE, "div_m7_2");
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, MD_NONE, "div_overflow");
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, MD_NONE, "multu_max");
    endtask

    task automatic test_move();
        do_move(MD_MTHI, 32'h1234_5678, "mthi_idle");
        do_move(MD_MTLO, 32'h8765_4321, "mtlo_idle");
        do_move(MD_NONE, 32'hDEAD_BEEF, "op_none");
        do_move(3'd7, 32'hCAFE_F00D, "op_reserved");
        // MTHI during busy is dropped; HI must reflect only the multiply.
        do_op(MD_MULT, 32'd6, 32'd7, 5, 1'b1, MD_MTHI, "mthi_while_busy");
    endtask

    task automatic test_div_zero();
        do_move(MD_MTHI, 32'h0000_00AA, "preload_hi");
        do_move(MD_MTLO, 32'h0000_00BB, "preload_lo");
        do_op(MD_DIV, 32'd5, 32'd0, 10, 1'b0, MD_NONE, "div_by_zero");
        do_op(MD_DIVU, 32'd9, 32'd0, 10, 1'b0, MD_NONE, "divu_by_zero");
    endtask

    task automatic test_back_to_back();
        do_op(MD_MULT, 32'hFFFF_FF00, 32'h0000_1000, 5, 1'b1, MD_DIV, "b2b_mult");
        do_op(MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 1'b0, MD_NONE, "b2b_divu");
        do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 1'b1, MD_MTLO, "b2b_multu");
    endtask

    task automatic test_reset_mid_op();
        int k;
        start = 1'b1; op = MD_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        for (k = 1; k < 3; k++) @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op_now: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op_after: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
            do_op(o, a, b, (o == MD_MULT || o == MD_MULTU) ? 5 : 10, 1'b0, MD_NONE, "random_op");
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_move();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_exec.md
MDU_EXEC -- requirements
Module: mdu_exec

Interface
REQ-001 Parameter MULT_CYC, default 5, busy-cycle count for MULT/MULTU.
REQ-002 Parameter DIV_CYC, default 10, busy-cycle count for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous active-low reset; reset=0 clears all state immediately.
REQ-005 start  input  1  E-stage request strobe, sampled at posedge; accepted only when busy=0.
REQ-006 op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 A  input  32  operand rs (V1_E after forwarding).
REQ-008 B  input  32  operand rt (V2_E after forwarding).
REQ-009 busy  output  1  registered; 1 while a multiply/divide is in flight.
REQ-010 HI  output  32  registered HI register.
REQ-011 LO  output  32  registered LO register.

Function
REQ-012 States SHALL be IDLE, MUL, DIV; a 4-bit down-counter SHALL track remaining cycles.
REQ-013 IDLE + start + op MULT/MULTU: capture product into temp regs, counter=MULT_CYC, go to MUL, busy=1 from next cycle.
REQ-014 IDLE + start + op DIV/DIVU: capture quotient/remainder into temp regs, counter=DIV_CYC, go to DIV, busy=1 from next cycle.
REQ-015 MUL/DIV: counter decrements each edge; on the edge where counter goes 1->0, HI/LO load temp results, busy falls, state returns to IDLE (busy high exactly MULT_CYC / DIV_CYC cycles).
REQ-016 MULT: {HI,LO} = signed 64-bit A*B; MULTU: unsigned 64-bit A*B.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of A; DIVU: unsigned quotient/remainder.
REQ-018 DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-019 Divide by zero (B=0): busy sequence still runs DIV_CYC cycles; HI and LO unchanged at completion.
REQ-020 IDLE + start + MTHI: HI=A at that edge, LO unchanged, busy stays 0; MTLO symmetric on LO.
REQ-021 start while busy=1 (any op, including MTHI/MTLO): ignored; in-flight operation and HI/LO unaffected.
REQ-022 start with op NONE/reserved: no state change.
REQ-023 Operands are sampled only on the accepting edge; A/B changes during busy have no effect.
REQ-024 HI/LO are read combinationally by E stage (MFHI/MFLO); hazard unit stalls D on (busy | start) and mdu_exec does no stalling itself.

Reset
REQ-025 reset=0 SHALL force state=IDLE, counter=0, busy=0, HI=0, LO=0, temp regs=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abandon the operation; no partial result reaches HI/LO after release.
REQ-027 First start after reset release SHALL be accepted on the first posedge with reset=1.

Structure
REQ-028 Op codes (MD_NONE..MD_MTLO) and default latencies SHALL live in the shared pipeline define package with the other opcode/func constants.
REQ-029 Single module, no sub-module; arithmetic via built-in signed/unsigned multiply, divide, modulo on captured operands.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 DIVU A=100, B=7 -> busy high 10 cycles, then LO=14, HI=2; DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 MTHI A=0x12345678 while idle -> HI=0x12345678 next edge, busy stays 0; repeat while busy -> HI unchanged.
REQ-033 DIV A=5, B=0 with HI=0xAA, LO=0xBB preloaded -> busy 10 cycles, HI=0xAA, LO=0xBB after.
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF, reset pulsed low on 3rd busy cycle -> busy=0, HI=LO=0 immediately, remain 0 after release.
REQ-035 Back-to-back: MULT accepted, second start (DIV) issued during busy -> ignored; next start on first busy=0 cycle accepted.
